memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
//  MIPS pipeline MEM stage, directly downstream of the execute stage.
//  - Owns the E/M pipeline register and drives the data-memory request/response bus for lw/sw.
//  - Resolves the branch decision (pcsrc, pc_branch) and supplies the forwarding value to execute.
//  - Presents M/W results to writeback.
//  - Raises mem_busy to the hazard unit while an access is outstanding.
// PARAMETERS
//  ADDR_W   32  data-memory address width
//  DATA_W   32  data width; word accesses only
// PORTS
//  clk            in   1       clock, all state updates on posedge
//  resetn         in   1       asynchronous, active-low reset
//  stall_m        in   1       hazard unit: hold the E/M register
//  flush_m        in   1       hazard unit: load a bubble instead of ex_*
//  ex_valid       in   1       execute output carries a real instruction
//  ex_reg_write   in   1       instruction writes the register file
//  ex_mem_to_reg  in   1       load (writeback selects read data)
//  ex_mem_write   in   1       store
//  ex_branch      in   1       beq-type branch
//  ex_zero        in   1       ALU zero flag
//  ex_alu_result  in   32      ALU result / memory address
//  ex_write_data  in   32      forwarded rt value for stores
//  ex_write_reg   in   5       destination register
//  ex_pc_branch   in   32      branch target
//  dreq_valid     out  1       data request valid
//  dreq_write     out  1       1 = store, 0 = load
//  dreq_addr      out  32      word address, bits [1:0] forced to 0
//  dreq_strobe    out  4       4'hF on store, 4'h0 on load
//  dreq_data      out  32      store data
//  dresp_addr_ok  in   1       request accepted
//  dresp_data_ok  in   1       data phase complete (load data valid)
//  dresp_data     in   32      load data
//  mem_busy       out  1       access outstanding; hazard unit stalls F/D/E/M
//  pcsrc          out  1       take branch
//  pc_branch      out  32      branch target
//  aluout_fwd     out  32      forwarding value to execute
//  write_reg_m    out  5       destination register, for hazard detection
//  reg_write_m    out  1       destination write enable, for hazard detection
//  wb_valid       out  1       M/W contents valid
//  wb_reg_write   out  1       M/W register-file write enable
//  wb_mem_to_reg  out  1       M/W writeback select
//  wb_write_reg   out  5       M/W destination register
//  wb_alu_result  out  32      M/W ALU result
//  wb_read_data   out  32      M/W load data
// BEHAVIOUR
//  - Reset (async, resetn=0): E/M register zeroed (m_valid=0), FSM=IDLE, rdata latch=0.
//    All outputs 0, dreq_valid=0. An access in flight is abandoned.
//  - advance = !stall_m & !mem_busy.
//    - On posedge with advance: register <= flush_m ? bubble (all 0) : ex_*.
//    - Otherwise the register holds; flush_m is ignored while mem_busy.
//  - mem = m_valid & (m_mem_to_reg | m_mem_write).
//  - FSM, separate from the E/M register:
//    - IDLE:
//      - mem & !done: dreq_valid=1.
//      - addr_ok & data_ok in the same cycle -> DONE; rdata latched on loads.
//      - addr_ok only -> WAIT_DATA.
//    - WAIT_DATA: dreq_valid=0; data_ok -> DONE, rdata latched on loads.
//    - DONE: hold until advance, then -> IDLE.
//  - dreq_* stay stable from dreq_valid rising until addr_ok; dreq_valid never deasserts before addr_ok.
//  - mem_busy = mem & (state!=DONE) & !(state==IDLE & addr_ok & data_ok)... simplified:
//    mem_busy = mem & !(state==DONE) & !data_ok_this_cycle.
//  - Bus latency: a zero-wait-state bus (addr_ok & data_ok on the request cycle) adds 0 stall cycles.
//  - dresp_data_ok seen in IDLE with no request is ignored.
//  - pcsrc = m_valid & m_branch & m_zero. pc_branch = m_pc_branch.
//  - aluout_fwd = m_alu_result. write_reg_m / reg_write_m = m_write_reg / m_reg_write & m_valid.
//  - wb_* are combinational from the E/M register plus the rdata latch.
//    - wb_valid = m_valid & !mem_busy.
//    - wb_read_data = data_ok this cycle ? dresp_data : rdata latch.
//  - Simultaneous stall_m & flush_m: stall wins (register holds).
// TESTING
//  - Reset mid-access: sw issued, addr_ok=1, resetn=0 before data_ok -> next cycle dreq_valid=0,
//    state IDLE, mem_busy=0, wb_valid=0.
//  - Zero-wait lw: ex_alu_result=0x100, addr_ok=data_ok=1 same cycle, dresp_data=0xDEADBEEF ->
//    dreq_addr=0x100, mem_busy=0, wb_read_data=0xDEADBEEF, wb_write_reg=ex value.
//  - Slow sw: address 0x203, data 0x12345678; addr_ok after 2 cycles, data_ok 3 cycles later ->
//    dreq_addr=0x200, strobe=4'hF, fields stable, mem_busy=1 for 5 cycles, register holds.
//  - Branch: ex_branch=1, ex_zero=1, ex_pc_branch=0x40 -> one cycle later pcsrc=1,
//    pc_branch=0x40. With ex_zero=0 -> pcsrc=0.
//  - Flush vs stall: flush_m=1 -> next cycle wb_valid=0, reg_write_m=0, pcsrc=0.
//    stall_m=1 & flush_m=1 -> register unchanged.
//  - Stray response: data_ok=1 with no load pending -> no state change, wb_read_data unchanged.

Source files
------------

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// MEM stage of the MIPS pipeline, directly downstream of execute.
//   - Owns the E/M pipeline register.
//   - Drives the data-memory request/response bus for lw/sw (word accesses).
//   - Resolves the branch decision and supplies the forwarding value to execute.
//   - Presents M/W results to writeback (combinational from the E/M register).
//   - Raises mem_busy to the hazard unit while an access is outstanding.
//
// Ports
//   clk, resetn            clock (posedge), asynchronous active-low reset
//   stall_m, flush_m       hazard unit: hold / load a bubble into E/M
//   ex_*                   execute-stage results for the next instruction
//   dreq_*                 data request: valid, write, word address, strobe, data
//   dresp_*                data response: addr_ok, data_ok, load data
//   mem_busy               access outstanding; hazard unit stalls F/D/E/M
//   pcsrc, pc_branch       branch decision and target
//   aluout_fwd             forwarding value to execute
//   write_reg_m,
//   reg_write_m            destination info for hazard detection
//   wb_*                   M/W results for writeback
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stall_m,
  input  logic                  flush_m,
  input  logic                  ex_valid,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_to_reg,
  input  logic                  ex_mem_write,
  input  logic                  ex_branch,
  input  logic                  ex_zero,
  input  logic [ADDR_W-1:0]     ex_alu_result,
  input  logic [DATA_W-1:0]     ex_write_data,
  input  logic [4:0]            ex_write_reg,
  input  logic [ADDR_W-1:0]     ex_pc_branch,
  output logic                  dreq_valid,
  output logic                  dreq_write,
  output logic [ADDR_W-1:0]     dreq_addr,
  output logic [DATA_W/8-1:0]   dreq_strobe,
  output logic [DATA_W-1:0]     dreq_data,
  input  logic                  dresp_addr_ok,
  input  logic                  dresp_data_ok,
  input  logic [DATA_W-1:0]     dresp_data,
  output logic                  mem_busy,
  output logic                  pcsrc,
  output logic [ADDR_W-1:0]     pc_branch,
  output logic [ADDR_W-1:0]     aluout_fwd,
  output logic [4:0]            write_reg_m,
  output logic                  reg_write_m,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [4:0]            wb_write_reg,
  output logic [ADDR_W-1:0]     wb_alu_result,
  output logic [DATA_W-1:0]     wb_read_data
);

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic              mem_write;
    logic              branch;
    logic              zero;
    logic [ADDR_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [4:0]        write_reg;
    logic [ADDR_W-1:0] pc_branch;
  } em_t;

  // IDLE: no access, or request being presented.
  // WAIT_DATA: address accepted, waiting for the data phase.
  // DONE: access finished but the E/M register has not advanced yet.
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_DATA = 2'd1,
    S_DONE      = 2'd2
  } state_t;

  em_t               r_em;
  em_t               w_em_load;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_rdata;

  logic w_mem;
  logic w_complete;
  logic w_advance;

  assign w_em_load = '{
    valid:      ex_valid,
    reg_write:  ex_reg_write,
    mem_to_reg: ex_mem_to_reg,
    mem_write:  ex_mem_write,
    branch:     ex_branch,
    zero:       ex_zero,
    alu_result: ex_alu_result,
    write_data: ex_write_data,
    write_reg:  ex_write_reg,
    pc_branch:  ex_pc_branch
  };

  assign w_mem = r_em.valid & (r_em.mem_to_reg | r_em.mem_write);

  // The data phase finishes this cycle: either a zero-wait handshake while the
  // request is presented, or data_ok after the address was accepted. A stray
  // data_ok with no access pending never counts.
  assign w_complete = w_mem &
                      (((r_state == S_IDLE) & dresp_addr_ok & dresp_data_ok) |
                       ((r_state == S_WAIT_DATA) & dresp_data_ok));

  // Finishing in the same cycle releases the stall, so a zero-wait bus costs
  // no extra cycles.
  assign mem_busy  = w_mem & (r_state != S_DONE) & ~w_complete;
  assign w_advance = ~stall_m & ~mem_busy;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_mem && dresp_addr_ok) begin
          if (!dresp_data_ok)  w_state_nxt = S_WAIT_DATA;
          else if (!w_advance) w_state_nxt = S_DONE;
        end
      end
      S_WAIT_DATA: begin
        if (dresp_data_ok) w_state_nxt = w_advance ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        if (w_advance) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_em    <= '0;
      r_state <= S_IDLE;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      // The register holds while busy, which keeps dreq_* stable until the
      // address is accepted; flush_m only acts when the stage can advance.
      if (w_advance) r_em <= flush_m ? '0 : w_em_load;
      if (w_complete && r_em.mem_to_reg) r_rdata <= dresp_data;
    end
  end

  // Data-memory request
  assign dreq_valid  = w_mem & (r_state == S_IDLE);
  assign dreq_write  = r_em.mem_write;
  assign dreq_addr   = {r_em.alu_result[ADDR_W-1:2], 2'b00};
  assign dreq_strobe = r_em.mem_write ? '1 : '0;
  assign dreq_data   = r_em.write_data;

  // Branch resolution and forwarding
  assign pcsrc       = r_em.valid & r_em.branch & r_em.zero;
  assign pc_branch   = r_em.pc_branch;
  assign aluout_fwd  = r_em.alu_result;
  assign write_reg_m = r_em.write_reg;
  assign reg_write_m = r_em.reg_write & r_em.valid;

  // M/W view; load data bypasses the latch on the completing cycle.
  assign wb_valid      = r_em.valid & ~mem_busy;
  assign wb_reg_write  = r_em.reg_write & r_em.valid;
  assign wb_mem_to_reg = r_em.mem_to_reg;
  assign wb_write_reg  = r_em.write_reg;
  assign wb_alu_result = r_em.alu_result;
  assign wb_read_data  = w_complete ? dresp_data : r_rdata;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        stall_m, flush_m;
  logic        ex_valid, ex_reg_write, ex_mem_to_reg, ex_mem_write, ex_branch, ex_zero;
  logic [31:0] ex_alu_result, ex_write_data, ex_pc_branch;
  logic [4:0]  ex_write_reg;
  logic        dreq_valid, dreq_write;
  logic [31:0] dreq_addr, dreq_data;
  logic [3:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        mem_busy, pcsrc;
  logic [31:0] pc_branch, aluout_fwd;
  logic [4:0]  write_reg_m;
  logic        reg_write_m;
  logic        wb_valid, wb_reg_write, wb_mem_to_reg;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_alu_result, wb_read_data;

  always #5 clk = ~clk;

  memory_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn), .stall_m(stall_m), .flush_m(flush_m),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_zero(ex_zero),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_write_reg(ex_write_reg), .ex_pc_branch(ex_pc_branch),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .mem_busy(mem_busy), .pcsrc(pcsrc), .pc_branch(pc_branch), .aluout_fwd(aluout_fwd),
    .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_write_reg(wb_write_reg), .wb_alu_result(wb_alu_result), .wb_read_data(wb_read_data)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the instruction held in MEM, whether its address has been
  // accepted, whether its data phase has finished, and the last load data.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          valid, rw, ld, st, br, z;
    logic [31:0] alu, wd, pc;
    logic [4:0]  wr;
  } inst_t;

  inst_t       m_inst;
  bit          m_addr_taken, m_finished;
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_inst       = '{default: 0};
    m_addr_taken = 0;
    m_finished   = 0;
    m_rdata      = '0;
  endtask

  function automatic inst_t ex_now();
    inst_t t;
    t.valid = ex_valid;     t.rw = ex_reg_write; t.ld = ex_mem_to_reg;
    t.st    = ex_mem_write; t.br = ex_branch;    t.z  = ex_zero;
    t.alu   = ex_alu_result; t.wd = ex_write_data; t.pc = ex_pc_branch;
    t.wr    = ex_write_reg;
    return t;
  endfunction

  // req: request should be on the bus; fin: access ends now; busy: stall needed
  function automatic void model_flags(output bit req, output bit fin, output bit busy);
    bit is_mem;
    is_mem = m_inst.valid && (m_inst.ld || m_inst.st);
    req    = is_mem && !m_addr_taken && !m_finished;
    fin    = is_mem && !m_finished &&
             (m_addr_taken ? dresp_data_ok : (dresp_addr_ok && dresp_data_ok));
    busy   = is_mem && !m_finished && !fin;
  endfunction

  task automatic check_model(input string ctx);
    bit req, fin, busy;
    model_flags(req, fin, busy);
    check({ctx, ".dreq_valid"},   dreq_valid, req);
    check({ctx, ".mem_busy"},     mem_busy, busy);
    check({ctx, ".dreq_write"},   dreq_write, m_inst.st);
    check({ctx, ".dreq_addr"},    dreq_addr, m_inst.alu & 32'hFFFF_FFFC);
    check({ctx, ".dreq_strobe"},  dreq_strobe, m_inst.st ? 32'hF : 32'h0);
    check({ctx, ".dreq_data"},    dreq_data, m_inst.wd);
    check({ctx, ".pcsrc"},        pcsrc, m_inst.valid && m_inst.br && m_inst.z);
    check({ctx, ".pc_branch"},    pc_branch, m_inst.pc);
    check({ctx, ".aluout_fwd"},   aluout_fwd, m_inst.alu);
    check({ctx, ".write_reg_m"},  write_reg_m, m_inst.wr);
    check({ctx, ".reg_write_m"},  reg_write_m, m_inst.valid && m_inst.rw);
    check({ctx, ".wb_valid"},     wb_valid, m_inst.valid && !busy);
    check({ctx, ".wb_reg_write"}, wb_reg_write, m_inst.valid && m_inst.rw);
    check({ctx, ".wb_mem_to_reg"}, wb_mem_to_reg, m_inst.ld);
    check({ctx, ".wb_write_reg"}, wb_write_reg, m_inst.wr);
    check({ctx, ".wb_alu_result"}, wb_alu_result, m_inst.alu);
    check({ctx, ".wb_read_data"}, wb_read_data, fin ? dresp_data : m_rdata);
  endtask

  // Check the current cycle against the model, then advance one clock.
  task automatic tick(input string ctx);
    bit req, fin, busy;
    #1;
    check_model(ctx);
    model_flags(req, fin, busy);
    @(posedge clk);
    if (fin && m_inst.ld) m_rdata = dresp_data;
    if (!stall_m && !busy) begin
      m_inst       = flush_m ? '{default: 0} : ex_now();
      m_addr_taken = 0;
      m_finished   = 0;
    end else if (fin) begin
      m_finished = 1;
    end else if (req && dresp_addr_ok) begin
      m_addr_taken = 1;
    end
    #1;
  endtask

  task automatic drive_ex(input bit v, input bit rw, input bit ld, input bit st,
                          input bit br, input bit z, input logic [31:0] alu,
                          input logic [31:0] wd, input logic [4:0] wr,
                          input logic [31:0] pc);
    ex_valid = v;  ex_reg_write = rw; ex_mem_to_reg = ld; ex_mem_write = st;
    ex_branch = br; ex_zero = z; ex_alu_result = alu; ex_write_data = wd;
    ex_write_reg = wr; ex_pc_branch = pc;
  endtask

  task automatic drive_bubble();
    drive_ex(0, 0, 0, 0, 0, 0, '0, '0, '0, '0);
  endtask

  task automatic drive_bus(input bit aok, input bit dok, input logic [31:0] d);
    dresp_addr_ok = aok; dresp_data_ok = dok; dresp_data = d;
  endtask

  initial begin
    int          busy_cycles;
    bit          pend;
    logic [31:0] pend_addr, pend_data;
    logic        pend_write;

    // ---- reset ----
    resetn = 1'b0; stall_m = 1'b0; flush_m = 1'b0;
    drive_bubble();
    drive_bus(0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.dreq_valid", dreq_valid, 0);
    check("rst.mem_busy", mem_busy, 0);
    check("rst.wb_valid", wb_valid, 0);
    check("rst.pcsrc", pcsrc, 0);
    check("rst.wb_read_data", wb_read_data, 0);
    resetn = 1'b1;
    tick("rst_release");

    // ---- zero-wait load ----
    drive_ex(1, 1, 1, 0, 0, 0, 32'h100, 32'h0, 5'd5, 32'h0);
    tick("lw_issue");
    drive_bubble();
    drive_bus(1, 1, 32'hDEADBEEF);
    #1;
    check("lw0.dreq_valid", dreq_valid, 1);
    check("lw0.dreq_addr", dreq_addr, 32'h100);
    check("lw0.mem_busy", mem_busy, 0);
    check("lw0.wb_valid", wb_valid, 1);
    check("lw0.wb_read_data", wb_read_data, 32'hDEADBEEF);
    check("lw0.wb_write_reg", wb_write_reg, 5'd5);
    tick("lw0");
    drive_bus(0, 0, '0);
    tick("lw0_after");

    // ---- slow store: addr_ok after 2 cycles, data_ok 3 cycles later ----
    drive_ex(1, 0, 0, 1, 0, 0, 32'h203, 32'h12345678, 5'd0, 32'h0);
    tick("sw_issue");
    drive_ex(1, 1, 0, 0, 0, 0, 32'h777, 32'h0, 5'd9, 32'h0);  // must wait behind the store
    busy_cycles = 0;
    for (int c = 0; c < 6; c++) begin
      drive_bus(c == 2, c == 5, 32'hA5A5_0000 + c);
      #1;
      if (mem_busy === 1'b1) busy_cycles++;
      check("sw.dreq_valid", dreq_valid, c <= 2);
      check("sw.dreq_addr", dreq_addr, 32'h200);
      check("sw.dreq_strobe", dreq_strobe, 4'hF);
      check("sw.dreq_data", dreq_data, 32'h12345678);
      check("sw.hold_alu", aluout_fwd, 32'h203);
      tick("sw");
    end
    check("sw.busy_cycles", busy_cycles, 5);
    drive_bus(0, 0, '0);
    drive_bubble();
    #1;
    check("sw.next_inst", aluout_fwd, 32'h777);
    tick("sw_after");

    // ---- branch ----
    drive_ex(1, 0, 0, 0, 1, 1, 32'h0, 32'h0, 5'd0, 32'h40);
    tick("beq_taken_issue");
    drive_ex(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 5'd0, 32'h40);
    #1;
    check("beq.pcsrc_taken", pcsrc, 1);
    check("beq.pc_branch", pc_branch, 32'h40);
    tick("beq_taken");
    drive_bubble();
    #1;
    check("beq.pcsrc_not_taken", pcsrc, 0);
    tick("beq_not_taken");

    // ---- flush, then stall+flush ----
    flush_m = 1'b1;
    drive_ex(1, 1, 0, 0, 1, 1, 32'h11, 32'h0, 5'd3, 32'h80);
    tick("flush_issue");
    flush_m = 1'b0;
    drive_ex(1, 1, 0, 0, 0, 0, 32'h55, 32'h0, 5'd7, 32'h0);
    #1;
    check("flush.wb_valid", wb_valid, 0);
    check("flush.reg_write_m", reg_write_m, 0);
    check("flush.pcsrc", pcsrc, 0);
    tick("flush");
    stall_m = 1'b1; flush_m = 1'b1;
    drive_ex(1, 1, 0, 0, 0, 0, 32'h99, 32'h0, 5'd9, 32'h0);
    tick("stall_flush");
    stall_m = 1'b0; flush_m = 1'b0;
    drive_bubble();
    #1;
    check("stall_flush.write_reg_m", write_reg_m, 5'd7);
    check("stall_flush.aluout_fwd", aluout_fwd, 32'h55);
    check("stall_flush.wb_valid", wb_valid, 1);
    tick("stall_flush_after");

    // ---- stray response ----
    drive_bus(1, 1, 32'hCAFEF00D);
    #1;
    check("stray.wb_read_data", wb_read_data, 32'hDEADBEEF);
    check("stray.mem_busy", mem_busy, 0);
    tick("stray");
    drive_bus(0, 0, '0);
    tick("stray_after");

    // ---- reset in the middle of a store ----
    drive_ex(1, 0, 0, 1, 0, 0, 32'h300, 32'h0BAD_F00D, 5'd0, 32'h0);
    tick("rst_sw_issue");
    drive_bubble();
    drive_bus(1, 0, '0);
    tick("rst_sw_addr_ok");
    drive_bus(0, 0, '0);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid.dreq_valid", dreq_valid, 0);
    check("rst_mid.mem_busy", mem_busy, 0);
    check("rst_mid.wb_valid", wb_valid, 0);
    check("rst_mid.wb_read_data", wb_read_data, 0);
    model_reset();
    resetn = 1'b1;
    tick("rst_mid_release");

    // ---- randomized traffic against the model ----
    pend = 0; pend_addr = '0; pend_data = '0; pend_write = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        case ($urandom_range(0, 3))
          0: drive_ex(1, 1, 0, 0, 0, 0, $urandom, '0, 5'($urandom), '0);
          1: drive_ex(1, 1, 1, 0, 0, 0, $urandom, '0, 5'($urandom), '0);
          2: drive_ex(1, 0, 0, 1, 0, 0, $urandom, $urandom, '0, '0);
          default: drive_ex(1, 0, 0, 0, 1, 1'($urandom), '0, '0, '0, $urandom);
        endcase
      end else begin
        drive_bubble();
      end
      stall_m = ($urandom_range(0, 99) < 15);
      flush_m = ($urandom_range(0, 99) < 10);
      drive_bus(1'($urandom), ($urandom_range(0, 9) < 4), $urandom);
      #1;
      if (pend) begin
        check("rnd.req_held", dreq_valid, 1);
        check("rnd.req_addr_stable", dreq_addr, pend_addr);
        check("rnd.req_data_stable", dreq_data, pend_data);
        check("rnd.req_write_stable", dreq_write, pend_write);
      end
      pend       = (dreq_valid === 1'b1) && dresp_addr_ok;
      pend       = (dreq_valid === 1'b1) && !pend;
      pend_addr  = dreq_addr;
      pend_data  = dreq_data;
      pend_write = dreq_write;
      tick("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
